// File: rtl/csr_access_arbiter_pkg.sv
// csr_access_arbiter_pkg
// Shared definitions for the CSR access arbiter slice: default geometry for warps, data width
// and warp-id width, fixed CSR field widths, and the arbiter FSM state type.
package csr_access_arbiter_pkg;

    localparam int unsigned DEF_NUM_WARP   = 4;
    localparam int unsigned DEF_XLEN       = 32;
    localparam int unsigned DEF_DEPTH_WARP = 2;

    localparam int unsigned INST_W = 32;
    localparam int unsigned RD_W   = 5;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StWb     = 2'd2
    } arb_state_e;

endpackage

// File: rtl/csr_access_arbiter_if.sv
// csr_access_arbiter_if
// Bundles every bus signal of the CSR access arbiter:
//   request side : req_valid_i / req_ready_o, per-warp req_inst_i, req_in1_i, req_rd_i
//   CTA side     : cta_valid_i, cta_wid_i / cta_ready_o
//   csrfile side : csr_sel_o, csr_write_o, csr_inst_o, csr_in1_o, csr_cta_valid_o, csr_rdata_i
//   writeback    : wb_valid_o / wb_ready_i, wb_wid_o, wb_rd_o, wb_data_o
// Suffixes are from the arbiter's point of view. modport slave = arbiter, master = environment.
interface csr_access_arbiter_if
    import csr_access_arbiter_pkg::*;
#(
    parameter int unsigned NUM_WARP   = DEF_NUM_WARP,
    parameter int unsigned XLEN       = DEF_XLEN,
    parameter int unsigned DEPTH_WARP = DEF_DEPTH_WARP
);
    logic [NUM_WARP-1:0]        req_valid_i;
    logic [NUM_WARP-1:0]        req_ready_o;
    logic [NUM_WARP*INST_W-1:0] req_inst_i;
    logic [NUM_WARP*XLEN-1:0]   req_in1_i;
    logic [NUM_WARP*RD_W-1:0]   req_rd_i;

    logic                       cta_valid_i;
    logic [DEPTH_WARP-1:0]      cta_wid_i;
    logic                       cta_ready_o;

    logic [NUM_WARP-1:0]        csr_sel_o;
    logic                       csr_write_o;
    logic [INST_W-1:0]          csr_inst_o;
    logic [XLEN-1:0]            csr_in1_o;
    logic [NUM_WARP-1:0]        csr_cta_valid_o;
    logic [XLEN-1:0]            csr_rdata_i;

    logic                       wb_valid_o;
    logic                       wb_ready_i;
    logic [DEPTH_WARP-1:0]      wb_wid_o;
    logic [RD_W-1:0]            wb_rd_o;
    logic [XLEN-1:0]            wb_data_o;

    modport slave (
        input  req_valid_i, req_inst_i, req_in1_i, req_rd_i,
        input  cta_valid_i, cta_wid_i, csr_rdata_i, wb_ready_i,
        output req_ready_o, cta_ready_o,
        output csr_sel_o, csr_write_o, csr_inst_o, csr_in1_o, csr_cta_valid_o,
        output wb_valid_o, wb_wid_o, wb_rd_o, wb_data_o
    );

    modport master (
        output req_valid_i, req_inst_i, req_in1_i, req_rd_i,
        output cta_valid_i, cta_wid_i, csr_rdata_i, wb_ready_i,
        input  req_ready_o, cta_ready_o,
        input  csr_sel_o, csr_write_o, csr_inst_o, csr_in1_o, csr_cta_valid_o,
        input  wb_valid_o, wb_wid_o, wb_rd_o, wb_data_o
    );

endinterface

// File: rtl/csr_access_arbiter_rr_picker.sv
// csr_rr_picker
// Combinational round-robin picker. Searches i_req starting at (i_ptr + 1) mod NUM_WARP.
//   i_req   : request vector
//   i_ptr   : last granted index
//   o_grant : one-hot grant (zero when nothing requests)
//   o_any   : at least one request present
module csr_rr_picker
    import csr_access_arbiter_pkg::*;
#(
    parameter int unsigned NUM_WARP   = DEF_NUM_WARP,
    parameter int unsigned DEPTH_WARP = DEF_DEPTH_WARP
) (
    input  logic [NUM_WARP-1:0]   i_req,
    input  logic [DEPTH_WARP-1:0] i_ptr,
    output logic [NUM_WARP-1:0]   o_grant,
    output logic                  o_any
);

    logic [DEPTH_WARP:0]     w_shamt;
    logic [2*NUM_WARP-1:0]   w_dbl;
    logic [2*NUM_WARP-1:0]   w_gnt_dbl;
    logic [NUM_WARP-1:0]     w_rot;
    logic [NUM_WARP-1:0]     w_rot_gnt;

    // Rotate so the search start lands on bit 0, isolate the lowest set bit, rotate back.
    // A shift of NUM_WARP (pointer at the last warp) leaves the vector unrotated, giving the wrap.
    always_comb begin
        w_shamt   = {1'b0, i_ptr} + (DEPTH_WARP+1)'(1);
        w_dbl     = {i_req, i_req};
        w_rot     = NUM_WARP'(w_dbl >> w_shamt);
        w_rot_gnt = w_rot & (~w_rot + NUM_WARP'(1));
        w_gnt_dbl = {{NUM_WARP{1'b0}}, w_rot_gnt} << w_shamt;
        o_grant   = w_gnt_dbl[NUM_WARP-1:0] | w_gnt_dbl[2*NUM_WARP-1:NUM_WARP];
        o_any     = |i_req;
    end

endmodule

// File: rtl/csr_access_arbiter.sv
// csr_access_arbiter
// Serialises per-warp CSR instructions and CTA dispatch writes onto a shared csrfile path.
// One CSR request is in flight at a time: IDLE (grant) -> ACCESS (one write strobe, capture
// read data) -> WB (hold writeback until accepted) -> IDLE.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request, CTA, csrfile and writeback signals (slave modport)
module csr_access_arbiter
    import csr_access_arbiter_pkg::*;
#(
    parameter int unsigned NUM_WARP   = DEF_NUM_WARP,
    parameter int unsigned XLEN       = DEF_XLEN,
    parameter int unsigned DEPTH_WARP = DEF_DEPTH_WARP
) (
    input logic                  clk,
    input logic                  rst_n,
    csr_access_arbiter_if.slave  bus
);

    arb_state_e              r_state;
    logic [DEPTH_WARP-1:0]   r_ptr;
    logic [DEPTH_WARP-1:0]   r_wid;
    logic [RD_W-1:0]         r_rd;
    logic [INST_W-1:0]       r_inst;
    logic [XLEN-1:0]         r_in1;
    logic [XLEN-1:0]         r_wb_data;
    logic [NUM_WARP-1:0]     r_csr_sel;
    logic                    r_csr_write;
    logic                    r_wb_valid;

    logic [NUM_WARP-1:0]     w_grant;
    logic                    w_any;
    logic                    w_grant_en;
    logic [DEPTH_WARP-1:0]   w_gnt_wid;
    logic [INST_W-1:0]       w_sel_inst;
    logic [XLEN-1:0]         w_sel_in1;
    logic [RD_W-1:0]         w_sel_rd;
    logic                    w_cta_block;
    logic                    w_cta_accept;
    logic [NUM_WARP-1:0]     w_cta_onehot;

    csr_rr_picker #(
        .NUM_WARP   (NUM_WARP),
        .DEPTH_WARP (DEPTH_WARP)
    ) u_picker (
        .i_req   (bus.req_valid_i),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    // Encode the one-hot grant and mux out the granted warp's fields.
    always_comb begin
        w_gnt_wid  = '0;
        w_sel_inst = '0;
        w_sel_in1  = '0;
        w_sel_rd   = '0;
        for (int i = 0; i < NUM_WARP; i++) begin
            if (w_grant[i]) begin
                w_gnt_wid  = DEPTH_WARP'(i);
                w_sel_inst = bus.req_inst_i[i*INST_W +: INST_W];
                w_sel_in1  = bus.req_in1_i[i*XLEN +: XLEN];
                w_sel_rd   = bus.req_rd_i[i*RD_W +: RD_W];
            end
        end
    end

    // A CTA write may not touch the csrfile of the warp whose request is in flight.
    assign w_cta_block  = (r_state != StIdle) && (bus.cta_wid_i == r_wid);
    assign w_cta_accept = rst_n && bus.cta_valid_i && !w_cta_block;
    assign w_cta_onehot = {{(NUM_WARP-1){1'b0}}, 1'b1} << bus.cta_wid_i;

    // Any valid CTA in IDLE is always accepted, so it alone suppresses the request grant.
    assign w_grant_en = rst_n && (r_state == StIdle) && !bus.cta_valid_i && w_any;

    assign bus.req_ready_o     = w_grant_en ? w_grant : '0;
    assign bus.cta_ready_o     = w_cta_accept;
    assign bus.csr_cta_valid_o = w_cta_accept ? w_cta_onehot : '0;

    assign bus.csr_sel_o   = r_csr_sel;
    assign bus.csr_write_o = r_csr_write;
    assign bus.csr_inst_o  = r_inst;
    assign bus.csr_in1_o   = r_in1;
    assign bus.wb_valid_o  = r_wb_valid;
    assign bus.wb_wid_o    = r_wid;
    assign bus.wb_rd_o     = r_rd;
    assign bus.wb_data_o   = r_wb_data;

    // The csr_* registers are only non-zero during ACCESS; they are loaded on grant and
    // cleared on the way out, so the csrfile sees a clean single-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_ptr       <= DEPTH_WARP'(NUM_WARP - 1);
            r_wid       <= '0;
            r_rd        <= '0;
            r_inst      <= '0;
            r_in1       <= '0;
            r_wb_data   <= '0;
            r_csr_sel   <= '0;
            r_csr_write <= 1'b0;
            r_wb_valid  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_grant_en) begin
                        r_state     <= StAccess;
                        r_ptr       <= w_gnt_wid;
                        r_wid       <= w_gnt_wid;
                        r_rd        <= w_sel_rd;
                        r_inst      <= w_sel_inst;
                        r_in1       <= w_sel_in1;
                        r_csr_sel   <= w_grant;
                        r_csr_write <= 1'b1;
                    end
                end
                StAccess: begin
                    r_state     <= StWb;
                    r_csr_sel   <= '0;
                    r_csr_write <= 1'b0;
                    r_inst      <= '0;
                    r_in1       <= '0;
                    r_wb_data   <= bus.csr_rdata_i;
                    r_wb_valid  <= 1'b1;
                end
                StWb: begin
                    if (bus.wb_ready_i) begin
                        r_state    <= StIdle;
                        r_wb_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_access_arbiter.sv
module tb_csr_access_arbiter;
    import csr_access_arbiter_pkg::*;

    localparam int unsigned NW = 4;
    localparam int unsigned XL = 32;
    localparam int unsigned DW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csr_access_arbiter_if #(.NUM_WARP(NW), .XLEN(XL), .DEPTH_WARP(DW)) bus ();

    csr_access_arbiter #(.NUM_WARP(NW), .XLEN(XL), .DEPTH_WARP(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Transaction-level model: age of the in-flight request (0 none, 1 strobe, >=2 writeback).
    int          m_age;
    int          m_last;
    int          m_wid;
    logic [4:0]  m_rd;
    logic [31:0] m_inst;
    logic [31:0] m_in1;
    logic [31:0] m_data;
    int          q_g[$];
    int          q_c[$];

    task automatic chk(input string tag, input string fld, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_age = 0; m_last = NW - 1; m_wid = 0; m_rd = '0;
        m_inst = '0; m_in1 = '0; m_data = '0;
    endtask

    function automatic int exp_grant();
        int idx;
        if (m_age != 0 || bus.cta_valid_i) return -1;
        for (int i = 1; i <= NW; i++) begin
            idx = (m_last + i) % NW;
            if (bus.req_valid_i[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic check_outputs(input string tag);
        int g;
        logic cr;
        g  = exp_grant();
        cr = bus.cta_valid_i && !(m_age > 0 && int'(bus.cta_wid_i) == m_wid);
        chk(tag, "req_ready", 64'(bus.req_ready_o), (g >= 0) ? 64'(1 << g) : 64'(0));
        chk(tag, "cta_ready", 64'(bus.cta_ready_o), 64'(cr));
        chk(tag, "cta_valid", 64'(bus.csr_cta_valid_o), cr ? 64'(1 << bus.cta_wid_i) : 64'(0));
        chk(tag, "csr_sel", 64'(bus.csr_sel_o), (m_age == 1) ? 64'(1 << m_wid) : 64'(0));
        chk(tag, "csr_write", 64'(bus.csr_write_o), 64'(m_age == 1));
        chk(tag, "csr_inst", 64'(bus.csr_inst_o), (m_age == 1) ? 64'(m_inst) : 64'(0));
        chk(tag, "csr_in1", 64'(bus.csr_in1_o), (m_age == 1) ? 64'(m_in1) : 64'(0));
        chk(tag, "wb_valid", 64'(bus.wb_valid_o), 64'(m_age >= 2));
        if (m_age >= 2) begin
            chk(tag, "wb_wid", 64'(bus.wb_wid_o), 64'(m_wid));
            chk(tag, "wb_rd", 64'(bus.wb_rd_o), 64'(m_rd));
            chk(tag, "wb_data", 64'(bus.wb_data_o), 64'(m_data));
        end
    endtask

    task automatic check_reset(input string tag);
        chk(tag, "req_ready", 64'(bus.req_ready_o), 64'(0));
        chk(tag, "cta_ready", 64'(bus.cta_ready_o), 64'(0));
        chk(tag, "cta_valid", 64'(bus.csr_cta_valid_o), 64'(0));
        chk(tag, "csr_sel", 64'(bus.csr_sel_o), 64'(0));
        chk(tag, "csr_write", 64'(bus.csr_write_o), 64'(0));
        chk(tag, "csr_inst", 64'(bus.csr_inst_o), 64'(0));
        chk(tag, "csr_in1", 64'(bus.csr_in1_o), 64'(0));
        chk(tag, "wb_valid", 64'(bus.wb_valid_o), 64'(0));
        chk(tag, "wb_wid", 64'(bus.wb_wid_o), 64'(0));
        chk(tag, "wb_rd", 64'(bus.wb_rd_o), 64'(0));
        chk(tag, "wb_data", 64'(bus.wb_data_o), 64'(0));
    endtask

    task automatic model_step();
        int g;
        g = exp_grant();
        if (m_age == 0) begin
            if (g >= 0) begin
                m_age  = 1;
                m_last = g;
                m_wid  = g;
                m_inst = 32'(bus.req_inst_i >> (32 * g));
                m_in1  = 32'(bus.req_in1_i >> (32 * g));
                m_rd   = 5'(bus.req_rd_i >> (5 * g));
                q_g.push_back(g);
                q_c.push_back(cyc);
            end
        end else if (m_age == 1) begin
            m_data = bus.csr_rdata_i;
            m_age  = 2;
        end else if (bus.wb_ready_i) begin
            m_age = 0;
        end else begin
            m_age++;
        end
    endtask

    // Check at the falling edge, then advance the model across the rising edge.
    task automatic tick_check(input string tag);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic tick_end();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick(input string tag);
        tick_check(tag);
        tick_end();
    endtask

    initial begin
        int exp_order[5];
        logic [31:0] held;
        exp_order = '{0, 1, 2, 3, 0};

        bus.req_valid_i = 4'b1111;
        bus.req_inst_i  = '0;
        bus.req_in1_i   = '0;
        bus.req_rd_i    = '0;
        bus.cta_valid_i = 1'b1;
        bus.cta_wid_i   = 2'd0;
        bus.csr_rdata_i = 32'hdead_beef;
        bus.wb_ready_i  = 1'b1;
        model_reset();

        // Reset: every output held low even with requests and CTA pending.
        #1;
        check_reset("rst0");
        @(posedge clk); @(posedge clk); #1;
        check_reset("rst1");
        bus.cta_valid_i = 1'b0;
        for (int i = 0; i < NW; i++) begin
            bus.req_inst_i[i*32 +: 32] = 32'h1000_0000 + 32'(i);
            bus.req_in1_i[i*32 +: 32]  = 32'h2000_0000 + 32'(i);
            bus.req_rd_i[i*5 +: 5]     = 5'(i + 8);
        end
        rst_n = 1'b1;

        // All warps requesting, writeback always ready: 0,1,2,3,0 every 3 cycles.
        q_g.delete(); q_c.delete();
        for (int i = 0; i < 15; i++) tick("rr");
        chk("rr", "n_grants", 64'(q_g.size()), 64'(5));
        for (int k = 0; k < 5 && k < q_g.size(); k++) begin
            chk("rr", "order", 64'(q_g[k]), 64'(exp_order[k]));
            chk("rr", "spacing", 64'(q_c[k] - q_c[0]), 64'(3 * k));
        end
        bus.req_valid_i = '0;
        tick("rr_drain");

        // Single request from warp 2: latency N / N+1 / N+2.
        bus.req_valid_i           = 4'b0100;
        bus.req_in1_i[2*32 +: 32] = 32'h55;
        bus.csr_rdata_i           = 32'hab;
        tick_check("single_n");
        chk("single_n", "req_ready", 64'(bus.req_ready_o), 64'(4'b0100));
        tick_end();
        bus.req_valid_i = '0;
        tick_check("single_n1");
        chk("single_n1", "csr_sel", 64'(bus.csr_sel_o), 64'(4'b0100));
        chk("single_n1", "csr_write", 64'(bus.csr_write_o), 64'(1));
        chk("single_n1", "csr_in1", 64'(bus.csr_in1_o), 64'(32'h55));
        tick_end();
        tick_check("single_n2");
        chk("single_n2", "wb_valid", 64'(bus.wb_valid_o), 64'(1));
        chk("single_n2", "wb_data", 64'(bus.wb_data_o), 64'(32'hab));
        chk("single_n2", "wb_wid", 64'(bus.wb_wid_o), 64'(2));
        tick_end();

        // CTA in IDLE wins over a request; the request is granted next cycle.
        bus.cta_valid_i = 1'b1;
        bus.cta_wid_i   = 2'd1;
        bus.req_valid_i = 4'b0001;
        tick_check("cta_prio");
        chk("cta_prio", "cta_valid", 64'(bus.csr_cta_valid_o), 64'(4'b0010));
        chk("cta_prio", "req_ready", 64'(bus.req_ready_o), 64'(0));
        tick_end();
        bus.cta_valid_i = 1'b0;
        tick_check("cta_next");
        chk("cta_next", "req_ready", 64'(bus.req_ready_o), 64'(4'b0001));
        tick_end();
        bus.req_valid_i = '0;
        tick("cta_acc");
        tick("cta_wb");

        // Warp 3 in WB: CTA to warp 3 stalls, CTA to warp 1 goes through.
        bus.req_valid_i = 4'b1000;
        tick("blk_g");
        bus.req_valid_i = '0;
        bus.wb_ready_i  = 1'b0;
        tick("blk_acc");
        bus.cta_valid_i = 1'b1;
        bus.cta_wid_i   = 2'd3;
        for (int i = 0; i < 2; i++) begin
            tick_check("blk_w3");
            chk("blk_w3", "cta_ready", 64'(bus.cta_ready_o), 64'(0));
            tick_end();
        end
        bus.cta_wid_i = 2'd1;
        tick_check("blk_w1");
        chk("blk_w1", "cta_ready", 64'(bus.cta_ready_o), 64'(1));
        chk("blk_w1", "cta_valid", 64'(bus.csr_cta_valid_o), 64'(4'b0010));
        tick_end();
        bus.cta_wid_i  = 2'd3;
        bus.wb_ready_i = 1'b1;
        tick_check("blk_hs");
        chk("blk_hs", "cta_ready", 64'(bus.cta_ready_o), 64'(0));
        tick_end();
        tick_check("blk_idle");
        chk("blk_idle", "cta_ready", 64'(bus.cta_ready_o), 64'(1));
        tick_end();
        bus.cta_valid_i = 1'b0;

        // Writeback backpressure: outputs stay put, no grant while waiting.
        bus.req_valid_i = 4'b0010;
        tick("bp_g");
        bus.req_valid_i = 4'b1111;
        bus.csr_rdata_i = 32'h1234_5678;
        bus.wb_ready_i  = 1'b0;
        tick("bp_acc");
        held = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            bus.csr_rdata_i = $urandom;
            tick_check("bp_hold");
            chk("bp_hold", "wb_data", 64'(bus.wb_data_o), 64'(held));
            chk("bp_hold", "wb_wid", 64'(bus.wb_wid_o), 64'(1));
            chk("bp_hold", "req_ready", 64'(bus.req_ready_o), 64'(0));
            tick_end();
        end
        bus.req_valid_i = '0;
        bus.wb_ready_i  = 1'b1;
        tick("bp_hs");
        tick("bp_idle");

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.req_valid_i = 4'($urandom);
            bus.cta_valid_i = ($urandom_range(0, 3) == 0);
            bus.cta_wid_i   = 2'($urandom);
            bus.wb_ready_i  = ($urandom_range(0, 2) != 0);
            bus.csr_rdata_i = $urandom;
            for (int w = 0; w < NW; w++) begin
                bus.req_inst_i[w*32 +: 32] = $urandom;
                bus.req_in1_i[w*32 +: 32]  = $urandom;
                bus.req_rd_i[w*5 +: 5]     = 5'($urandom);
            end
            tick("rand");
        end

        // Drain, then reset in the middle of ACCESS.
        bus.req_valid_i = '0;
        bus.cta_valid_i = 1'b0;
        bus.wb_ready_i  = 1'b1;
        for (int i = 0; i < 4; i++) tick("drain");
        bus.req_valid_i = 4'b0100;
        tick("mid_g");
        rst_n           = 1'b0;
        bus.cta_valid_i = 1'b1;
        #1;
        check_reset("mid_rst0");
        @(posedge clk); #1;
        check_reset("mid_rst1");
        model_reset();
        bus.cta_valid_i = 1'b0;
        bus.req_valid_i = 4'b1111;
        rst_n           = 1'b1;
        tick_check("post_rst");
        chk("post_rst", "req_ready", 64'(bus.req_ready_o), 64'(4'b0001));
        tick_end();
        bus.req_valid_i = '0;
        for (int i = 0; i < 4; i++) tick("post_run");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_access_arbiter.md
CSR_ACCESS_ARBITER -- requirements
Module: csr_access_arbiter

Interface
REQ-001 SHALL have parameter NUM_WARP, default `NUM_WARP, number of warps sharing the CSR path.
REQ-002 SHALL have parameter XLEN, default `XLEN, data width.
REQ-003 SHALL have parameter DEPTH_WARP, default `DEPTH_WARP, warp-id width.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid_i, input, NUM_WARP, per-warp CSR instruction request.
REQ-007 SHALL have port req_ready_o, output, NUM_WARP, one-hot grant.
REQ-008 SHALL have port req_inst_i, input, NUM_WARP*32, per-warp instruction word.
REQ-009 SHALL have port req_in1_i, input, NUM_WARP*XLEN, per-warp rs1 operand.
REQ-010 SHALL have port req_rd_i, input, NUM_WARP*5, per-warp destination register.
REQ-011 SHALL have port cta_valid_i, input, 1, CTA dispatch write request.
REQ-012 SHALL have port cta_wid_i, input, DEPTH_WARP, target warp of the CTA write.
REQ-013 SHALL have port cta_ready_o, output, 1, CTA write accepted.
REQ-014 SHALL have port csr_sel_o, output, NUM_WARP, one-hot per-warp csrfile select.
REQ-015 SHALL have port csr_write_o, output, 1, csrfile write_i strobe.
REQ-016 SHALL have port csr_inst_o, output, 32, instruction to the csrfile.
REQ-017 SHALL have port csr_in1_o, output, XLEN, operand to the csrfile.
REQ-018 SHALL have port csr_cta_valid_o, output, NUM_WARP, one-hot CTA2csr_valid per warp.
REQ-019 SHALL have port csr_rdata_i, input, XLEN, wb_wxd_rd_o of the selected csrfile.
REQ-020 SHALL have port wb_valid_o, output, 1, writeback valid.
REQ-021 SHALL have port wb_ready_i, input, 1, writeback ready.
REQ-022 SHALL have port wb_wid_o, output, DEPTH_WARP, writeback warp id.
REQ-023 SHALL have port wb_rd_o, output, 5, writeback destination register.
REQ-024 SHALL have port wb_data_o, output, XLEN, writeback data.

Function
REQ-025 SHALL implement FSM IDLE -> ACCESS -> WB -> IDLE; one CSR request in flight at a time.
REQ-026 SHALL, in IDLE with any req_valid_i and no accepted CTA, grant exactly one warp by round-robin, latch its inst/in1/rd/wid, and go to ACCESS.
REQ-027 SHALL assert req_ready_o combinationally in the grant cycle only; req_ready_o is 0 in ACCESS and WB.
REQ-028 SHALL start the round-robin search at (last granted wid + 1) mod NUM_WARP, and the pointer SHALL update on grant.
REQ-029 SHALL, in ACCESS, drive csr_sel_o = one-hot(wid) and csr_write_o = 1 for exactly one cycle, capture csr_rdata_i into wb_data, and go to WB.
REQ-030 SHALL, in WB, hold wb_valid_o = 1 with stable wb_* outputs until wb_valid_o & wb_ready_i, then go to IDLE.
REQ-031 SHALL give a latency of grant at cycle N, write strobe at N+1, and wb_valid_o at N+2; with wb_ready_i held high, back-to-back grants occur every 3 cycles.
REQ-032 SHALL accept a CTA write (cta_ready_o = 1, csr_cta_valid_o = one-hot(cta_wid_i) for that cycle) in any state unless cta_wid_i equals the in-flight wid in ACCESS or WB.
REQ-033 SHALL give a CTA write accepted in IDLE priority over requests; no req_ready_o is asserted that cycle.
REQ-034 SHALL stall a CTA write targeting the in-flight warp (cta_ready_o = 0) until the FSM returns to IDLE.
REQ-035 SHALL drive csr_sel_o, csr_write_o, csr_inst_o and csr_in1_o to 0 outside ACCESS.
REQ-036 SHALL treat a single requester as granted every time.
REQ-037 SHALL make the round-robin pointer wrap from NUM_WARP-1 to 0.

Reset
REQ-038 SHALL on rst_n low set FSM = IDLE, rr pointer = NUM_WARP-1 so warp 0 is searched first, and all latched fields and wb_data to 0.
REQ-039 SHALL hold all outputs at 0 during reset.
REQ-040 SHALL discard any in-flight request on reset mid-operation, with no write strobe or wb_valid_o after reset release.

Structure
REQ-041 SHALL take NUM_WARP, DEPTH_WARP and XLEN from the shared define.v, with FSM state encodings as local constants.
REQ-042 SHALL place the round-robin picker in sub-module csr_rr_picker (inputs request vector and pointer; outputs one-hot grant and any-grant).

Verification
REQ-043 SHALL cover: single request warp 2, in1 = 0x55, csr_rdata_i = 0xAB -> grant at N, csr_sel_o = 0b0100 with strobe at N+1, wb_valid_o with wb_data_o = 0xAB and wb_wid_o = 2 at N+2.
REQ-044 SHALL cover: all 4 warps requesting continuously, wb_ready_i = 1 -> grants in order 0,1,2,3,0 every 3 cycles.
REQ-045 SHALL cover: cta_valid_i with cta_wid_i = 1 and req_valid_i = 0b0001 in IDLE -> csr_cta_valid_o = 0b0010 and req_ready_o = 0 that cycle, warp 0 granted the next cycle.
REQ-046 SHALL cover: warp 3 in WB, CTA to warp 3 -> cta_ready_o = 0 until IDLE; CTA to warp 1 -> accepted immediately.
REQ-047 SHALL cover: wb_ready_i = 0 for 5 cycles in WB -> wb_* outputs stable and no new grant; handshake -> IDLE.
REQ-048 SHALL cover: rst_n asserted in ACCESS -> all outputs 0; after release the first grant goes to warp 0.
